// File: rtl/free_list_ctrl_pkg.sv
// Shared CPU sizing parameters and types used by the rename-stage blocks.
// The free list holds the PRNs above the architectural range.
package cpu_design_params;

  localparam int NUM_A_REGS    = 32;
  localparam int NUM_P_REGS    = 48;
  localparam int MAX_FREE_REGS = NUM_P_REGS - NUM_A_REGS;
  localparam int F_LIST_WDTH   = $clog2(MAX_FREE_REGS);
  localparam int P_REG_WDTH    = $clog2(NUM_P_REGS);

  typedef logic [P_REG_WDTH-1:0] prn_t;
  typedef logic [F_LIST_WDTH:0]  fl_ptr_t;

  localparam int FL_RESET_BASE = NUM_A_REGS;

endpackage

// File: rtl/free_list_ctrl.sv
// Physical-register free list: one speculative allocation and one committed
// release per cycle, with single-cycle flush back to the committed head.
module free_list_ctrl
  import cpu_design_params::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output prn_t                 alloc_prn,
  input  logic                 commit_valid,
  input  logic                 commit_writes_rd,
  input  prn_t                 commit_p_old,
  input  logic                 flush,
  output logic [F_LIST_WDTH:0] free_cnt,
  output logic                 empty,
  output logic                 err
);

  prn_t    list [MAX_FREE_REGS];
  fl_ptr_t head;
  fl_ptr_t c_head;
  fl_ptr_t tail;
  fl_ptr_t spec_cnt;
  fl_ptr_t c_head_nxt;
  logic    commit_push;
  logic    commit_bad;
  logic    commit_ok;

  // Wrap bit makes full (16) and empty (0) distinguishable with plain subtraction.
  assign free_cnt = tail - head;
  assign spec_cnt = head - c_head;
  assign empty    = (free_cnt == '0);

  // No push-to-pop bypass: a PRN released this cycle is only visible next cycle.
  assign alloc_gnt = alloc_req & ~empty & ~flush & ~rst;
  assign alloc_prn = list[head[F_LIST_WDTH-1:0]];

  assign commit_push = commit_valid & commit_writes_rd;
  assign commit_bad  = commit_push &
                       ((free_cnt == fl_ptr_t'(MAX_FREE_REGS)) || (spec_cnt == '0));
  assign commit_ok   = commit_push & ~commit_bad;
  assign c_head_nxt  = commit_ok ? c_head + fl_ptr_t'(1) : c_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the list array is reset on purpose -- its contents are the
      // free PRNs themselves, so leaving it unreset would hand out garbage.
      for (int i = 0; i < MAX_FREE_REGS; i++) begin
        list[i] <= prn_t'(FL_RESET_BASE + i);
      end
      head   <= '0;
      c_head <= '0;
      tail   <= fl_ptr_t'(MAX_FREE_REGS);
      err    <= 1'b0;
    end else begin
      if (commit_ok) begin
        list[tail[F_LIST_WDTH-1:0]] <= commit_p_old;
        tail <= tail + fl_ptr_t'(1);
      end
      c_head <= c_head_nxt;
      // Flush restores head to the committed pointer including this cycle's commit.
      if (flush) begin
        head <= c_head_nxt;
      end else if (alloc_gnt) begin
        head <= head + fl_ptr_t'(1);
      end
      if (commit_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule
